// File: rtl/cpu_0_div_cell_if.sv
// Handshake and operand bundle between the cpu_0 A-stage and its divide cell.
interface cpu_0_div_cell_if;
    logic [31:0] A_div_src1;
    logic [31:0] A_div_src2;
    logic        A_div_signed;
    logic        A_div_start;
    logic        A_div_busy;
    logic        A_div_done;
    logic [31:0] A_div_quot;
    logic [31:0] A_div_rem;

    modport master (
        output A_div_src1, A_div_src2, A_div_signed, A_div_start,
        input  A_div_busy, A_div_done, A_div_quot, A_div_rem
    );

    modport slave (
        input  A_div_src1, A_div_src2, A_div_signed, A_div_start,
        output A_div_busy, A_div_done, A_div_quot, A_div_rem
    );
endinterface

// File: rtl/cpu_0_div_cell.sv
// Iterative 32-bit radix-2 restoring divider with sign fix-up; fixed 33-cycle
// latency from accepted start to the one-cycle done pulse.
module cpu_0_div_cell (
    input  logic             clk,
    input  logic             reset_n,
    cpu_0_div_cell_if.slave  div_if
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_q;
    logic [31:0] r_d;
    logic [32:0] r_r;
    logic [31:0] r_dividend;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div0;
    logic [4:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_quot;
    logic [31:0] r_rem;

    logic [32:0] w_shift;
    logic [32:0] w_trial;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
        logic [31:0] m;
        if (sgn && v[31]) begin
            m = 32'd0 - v;
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Trial subtraction for the current iteration and the sign/div0 fix-up values.
    always_comb begin
        w_shift = {r_r[31:0], r_q[31]};
        w_trial = w_shift - {1'b0, r_d};
        if (r_div0) begin
            w_quot_fix = 32'hFFFF_FFFF;
            w_rem_fix  = r_dividend;
        end else begin
            w_quot_fix = r_neg_q ? (32'd0 - r_q) : r_q;
            w_rem_fix  = r_neg_r ? (32'd0 - r_r[31:0]) : r_r[31:0];
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_q        <= 32'd0;
            r_d        <= 32'd0;
            r_r        <= 33'd0;
            r_dividend <= 32'd0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div0     <= 1'b0;
            r_cnt      <= 5'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_quot     <= 32'd0;
            r_rem      <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (div_if.A_div_start) begin
                        r_q        <= magnitude(div_if.A_div_src1, div_if.A_div_signed);
                        r_d        <= magnitude(div_if.A_div_src2, div_if.A_div_signed);
                        r_r        <= 33'd0;
                        r_dividend <= div_if.A_div_src1;
                        r_neg_q    <= div_if.A_div_signed & (div_if.A_div_src1[31] ^ div_if.A_div_src2[31]);
                        r_neg_r    <= div_if.A_div_signed & div_if.A_div_src1[31];
                        r_div0     <= (div_if.A_div_src2 == 32'd0);
                        r_cnt      <= 5'd31;
                        r_busy     <= 1'b1;
                        r_state    <= S_ITER;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ITER: begin
                    // A borrow in bit 32 means the divisor did not fit: restore.
                    if (!w_trial[32]) begin
                        r_r <= w_trial;
                        r_q <= {r_q[30:0], 1'b1};
                    end else begin
                        r_r <= w_shift;
                        r_q <= {r_q[30:0], 1'b0};
                    end
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_state <= S_ITER;
                    end
                end
                S_FIX: begin
                    r_quot  <= w_quot_fix;
                    r_rem   <= w_rem_fix;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign div_if.A_div_busy = r_busy;
    assign div_if.A_div_done = r_done;
    assign div_if.A_div_quot = r_quot;
    assign div_if.A_div_rem  = r_rem;

endmodule

// File: tb/tb_cpu_0_div_cell.sv
// Scoreboard bench for cpu_0_div_cell: directed operations push expected
// quotient/remainder/done-cycle; a negedge monitor pops and compares on done.
module tb_cpu_0_div_cell;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          cyc;
        string       name;
    } exp_t;

    logic clk;
    logic reset_n;
    int   cyc;
    int   total;
    int   bad;
    exp_t sb[$];
    exp_t mon_e;

    cpu_0_div_cell_if div_if();

    cpu_0_div_cell dut (
        .clk     (clk),
        .reset_n (reset_n),
        .div_if  (div_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (div_if.A_div_done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                check32({mon_e.name, "_quot"}, div_if.A_div_quot, mon_e.q);
                check32({mon_e.name, "_rem"}, div_if.A_div_rem, mon_e.r);
                check32({mon_e.name, "_cycle"}, cyc, mon_e.cyc);
                check32({mon_e.name, "_busy_at_done"}, {31'd0, div_if.A_div_busy}, 32'd0);
            end
        end
    end

    // Drive one start strobe (caller is just after a negedge) and record the expectation.
    task automatic issue(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [31:0] eq, input logic [31:0] er);
        exp_t e;
        e.q = eq;
        e.r = er;
        e.cyc = cyc + 34;
        e.name = nm;
        sb.push_back(e);
        div_if.A_div_src1   = a;
        div_if.A_div_src2   = b;
        div_if.A_div_signed = sgn;
        div_if.A_div_start  = 1'b1;
        @(negedge clk);
        div_if.A_div_start  = 1'b0;
        div_if.A_div_src1   = 32'hDEAD_BEEF;
        div_if.A_div_src2   = 32'h0000_0000;
    endtask

    // Bounded wait that returns at the negedge where done is seen.
    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (div_if.A_div_done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (div_if.A_div_done !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout: got no done after %0d cycles expected done", nm, n);
        end
    endtask

    initial begin
        int seen;
        total = 0;
        bad = 0;
        reset_n = 1'b0;
        div_if.A_div_src1   = 32'd0;
        div_if.A_div_src2   = 32'd0;
        div_if.A_div_signed = 1'b0;
        div_if.A_div_start  = 1'b0;
        repeat (3) @(negedge clk);
        check32("reset_busy", {31'd0, div_if.A_div_busy}, 32'd0);
        check32("reset_done", {31'd0, div_if.A_div_done}, 32'd0);
        check32("reset_quot", div_if.A_div_quot, 32'd0);
        check32("reset_rem", div_if.A_div_rem, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        issue("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
        check32("u100_7_busy", {31'd0, div_if.A_div_busy}, 32'd1);
        wait_done("u100_7");
        @(negedge clk);

        issue("s_m7_2", 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        wait_done("s_m7_2");
        @(negedge clk);
        issue("s_7_m2", 32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'h0000_0001);
        wait_done("s_7_m2");
        @(negedge clk);
        issue("s_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE);
        wait_done("s_m100_m7");
        @(negedge clk);
        issue("u_fff9_2", 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'h7FFF_FFFC, 32'h0000_0001);
        wait_done("u_fff9_2");
        @(negedge clk);
        issue("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0000_0000);
        wait_done("s_ovf");
        @(negedge clk);
        issue("u_max_1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000);
        wait_done("u_max_1");
        @(negedge clk);
        issue("u_max_16", 32'hFFFF_FFFF, 32'h0000_0010, 1'b0, 32'h0FFF_FFFF, 32'h0000_000F);
        wait_done("u_max_16");
        @(negedge clk);
        issue("s_div0", 32'h0000_1234, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 32'h0000_1234);
        wait_done("s_div0");
        @(negedge clk);
        issue("u_div0", 32'h0000_1234, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234);
        wait_done("u_div0");
        @(negedge clk);

        // Second start while busy must be ignored.
        issue("u50_5", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0);
        repeat (8) @(negedge clk);
        div_if.A_div_src1  = 32'd9;
        div_if.A_div_src2  = 32'd3;
        div_if.A_div_start = 1'b1;
        @(negedge clk);
        check32("busy_during_restart", {31'd0, div_if.A_div_busy}, 32'd1);
        div_if.A_div_start = 1'b0;
        wait_done("u50_5");
        // Start in the done cycle is accepted.
        issue("u9_3_b2b", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);
        wait_done("u9_3_b2b");
        @(negedge clk);

        // Reset during iteration 10 abandons the operation.
        div_if.A_div_src1   = 32'd1000;
        div_if.A_div_src2   = 32'd3;
        div_if.A_div_signed = 1'b0;
        div_if.A_div_start  = 1'b1;
        @(negedge clk);
        div_if.A_div_start  = 1'b0;
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check32("rst_mid_busy", {31'd0, div_if.A_div_busy}, 32'd0);
        check32("rst_mid_done", {31'd0, div_if.A_div_done}, 32'd0);
        check32("rst_mid_quot", div_if.A_div_quot, 32'd0);
        check32("rst_mid_rem", div_if.A_div_rem, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_if.A_div_done === 1'b1) seen++;
        end
        check32("no_done_after_reset", seen, 32'd0);

        issue("u1000_3", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1);
        wait_done("u1000_3");
        repeat (3) @(negedge clk);
        check32("scoreboard_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_0_div_cell.md
# cpu_0_div_cell

Iterative 32-bit integer divider for the cpu_0 datapath, the inverse-operation companion to the pipelined multiply cell in the same A-stage. It accepts a dividend/divisor pair on a single-cycle start strobe, runs a radix-2 restoring division over 32 iterations, applies sign correction, and returns quotient and remainder with a one-cycle done pulse. The CPU stalls its A-stage on busy and captures results on done.

## Interface
- No parameters; the operand width is fixed at 32.
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- A_div_src1  in  32  dividend; sampled only on an accepted start.
- A_div_src2  in  32  divisor; sampled only on an accepted start.
- A_div_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled on an accepted start.
- A_div_start  in  1  start strobe; accepted only when busy=0.
- A_div_busy  out  1  operation in progress.
- A_div_done  out  1  one-cycle pulse; results valid.
- A_div_quot  out  32  quotient; held until the next done.
- A_div_rem  out  32  remainder; held until the next done.

## Operation
- States: IDLE, ITER, FIX.
- IDLE with start=1:
  - Latch the dividend magnitude into the quotient shift register Q (32 bits) and the divisor magnitude into D (32 bits).
  - Clear the partial remainder R (33 bits).
  - Latch the original dividend, neg_q = signed & (src1[31] ^ src2[31]), neg_r = signed & src1[31], and div0 = (src2 == 0).
  - Set counter = 31 and go to ITER.
  - Magnitude is the two's-complement negate when signed and bit 31 = 1; otherwise the raw value. 0x80000000 maps to 0x80000000 unsigned.
- ITER, each cycle:
  - t = {R[31:0], Q[31]} − {1'b0, D}, computed 33 bits wide.
  - If t is non-negative (t[32]=0): R = t and Q = {Q[30:0], 1}. Otherwise: R = {R[31:0], Q[31]} and Q = {Q[30:0], 0}.
  - Decrement counter. On the iteration where counter = 0, go to FIX.
- FIX, one cycle:
  - Quotient = neg_q ? −Q : Q. Remainder = neg_r ? −R[31:0] : R[31:0].
  - If div0: quotient = 0xFFFFFFFF and remainder = the original dividend, regardless of signed.
  - Register both outputs, pulse done, return to IDLE.
- Quotient truncates toward zero; the remainder takes the dividend's sign.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0, with no special case.
- start while busy=1 is ignored; operands are not re-sampled.
- Input changes during ITER/FIX have no effect.

## Timing
- Reset values: busy=0, done=0, quot=0, rem=0, state=IDLE, and all internal registers 0.
- Start sampled at edge E0. busy rises after E0. ITER occupies edges E1–E32. FIX executes at E33.
- After E33: done=1, busy=0, and the result is valid. Total latency from the start edge to done is 33 cycles, independent of operand values.
- done is high for exactly one cycle.
- busy and done are never both 1.
- A new start may be asserted in the same cycle that done=1; it is accepted, because busy=0.
- Back-to-back operations issue every 34 cycles.
- reset_n low at any point (mid-ITER, in FIX, or while done=1):
  - The operation is abandoned and all outputs return to reset values immediately.
  - No done pulse follows.
  - The first start after reset release behaves normally.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Unsigned 100 / 7, start at edge E0: busy goes high, then done=1 exactly 33 cycles later with quot=14 and rem=2. busy is low in the done cycle.
- Signed −7 / 2 (0xFFFFFFF9 / 0x00000002): quot=0xFFFFFFFD, rem=0xFFFFFFFF. Also signed 7 / −2: quot=0xFFFFFFFD, rem=0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF: quot=0x80000000, rem=0. Unsigned 0xFFFFFFFF / 1: quot=0xFFFFFFFF, rem=0.
- Divide by zero, 0x00001234 / 0 in both signed and unsigned modes: quot=0xFFFFFFFF, rem=0x00001234, with done still at 33 cycles.
- Start 50 / 5; re-assert start with 9 / 3 at cycle 10. Required response: the second start is ignored and the result is quot=10, rem=0. Then assert start in the done cycle with 9 / 3: accepted, yielding quot=3, rem=0 33 cycles later.
- Start 1000 / 3; pull reset_n low during iteration 10. Required response: busy=0, done=0, quot=0, rem=0 immediately, and no done pulse. After release, 1000 / 3 returns quot=333, rem=1.
